// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
//   Multi-cycle restoring divider. Divides an unsigned WIDTH-bit dividend by
//   an unsigned WIDTH-bit divisor, producing one quotient bit per clock.
//   Successor to the combinational div_top; meant to sit beside the ALU.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request pulse, sampled only while ready=1
//   sgn          in   (DIV_SEQ_SIGNED_EN only) operands are two's complement
//   a            in   dividend, captured on an accepted start
//   b            in   divisor, captured on an accepted start
//   ready        out  1 in IDLE or DONE, i.e. a start will be accepted
//   done         out  one-cycle pulse when q/r/div_by_zero become valid
//   q            out  quotient (registered, held until the next result)
//   r            out  remainder (registered, held until the next result)
//   div_by_zero  out  set with a zero divisor, held with q/r
//
// Configuration
//   DIV_SEQ_SIGNED_EN  adds the sgn input. Magnitudes are divided and the
//                      signs are applied as the result is loaded, so the
//                      signed path costs no extra cycles.
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef DIV_SEQ_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  // Derived from WIDTH; kept local so it cannot be overridden.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   remOut_q, remOut_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     remShift;
  logic [WIDTH-1:0]   remSub;
  logic               remGeq;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   shiftNext;
  logic [WIDTH-1:0]   accMagA;
  logic [WIDTH-1:0]   accMagB;
  logic [WIDTH-1:0]   quotFinal;
  logic [WIDTH-1:0]   remFinal;

  // One restoring step. The shifted partial remainder carries an extra bit
  // so the compare against the divisor can never wrap. When the compare
  // passes, the true difference is below 2^WIDTH, so a WIDTH-bit subtract
  // is exact.
  assign remShift  = {rem_q, shift_q[WIDTH-1]};
  assign remGeq    = (remShift >= {1'b0, divisor_q});
  assign remSub    = remShift[WIDTH-1:0] - divisor_q;
  assign remNext   = remGeq ? remSub : remShift[WIDTH-1:0];
  assign shiftNext = {shift_q[WIDTH-2:0], remGeq};

`ifdef DIV_SEQ_SIGNED_EN
  logic accNegA, accNegB;
  logic negQ_q, negQ_d;
  logic negR_q, negR_d;

  // Negating -2^(WIDTH-1) gives the same bit pattern, which read unsigned
  // is the correct magnitude; the overflow case then wraps naturally.
  assign accNegA   = sgn & a[WIDTH-1];
  assign accNegB   = sgn & b[WIDTH-1];
  assign accMagA   = accNegA ? -a : a;
  assign accMagB   = accNegB ? -b : b;
  // Quotient truncates toward zero; remainder follows the dividend sign.
  assign quotFinal = negQ_q ? -shiftNext : shiftNext;
  assign remFinal  = negR_q ? -remNext : remNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negQ_q <= 1'b0;
      negR_q <= 1'b0;
    end else begin
      negQ_q <= negQ_d;
      negR_q <= negR_d;
    end
  end
`else
  assign accMagA   = a;
  assign accMagB   = b;
  assign quotFinal = shiftNext;
  assign remFinal  = remNext;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      shift_q   <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      remOut_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      shift_q   <= shift_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      remOut_q  <= remOut_d;
      dbz_q     <= dbz_d;
    end
  end

  // Next-state logic. IDLE and DONE share the accept path so a start in the
  // DONE cycle launches the next division back to back. Results are written
  // only on entry to DONE and otherwise hold.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    shift_d   = shift_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    remOut_d  = remOut_q;
    dbz_d     = dbz_q;
`ifdef DIV_SEQ_SIGNED_EN
    negQ_d    = negQ_q;
    negR_d    = negR_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          divisor_d = accMagB;
          shift_d   = accMagA;
          rem_d     = '0;
          cnt_d     = CNT_W'(WIDTH);
`ifdef DIV_SEQ_SIGNED_EN
          negQ_d    = accNegA ^ accNegB;
          negR_d    = accNegA;
`endif
          if (b == '0) begin
            state_d  = DONE;
            quot_d   = '1;
            remOut_d = a;
            dbz_d    = 1'b1;
          end else begin
            state_d  = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        rem_d   = remNext;
        shift_d = shiftNext;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          quot_d   = quotFinal;
          remOut_d = remFinal;
          dbz_d    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign ready       = (state_q != RUN);
  assign done        = (state_q == DONE);
  assign q           = quot_q;
  assign r           = remOut_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
//   Self-checking bench for div_seq at WIDTH=6. Each started operation
//   pushes its expected quotient, remainder, flag and accept edge onto a
//   scoreboard; every done pulse pops one entry and compares.
//   Signed cases are built only when DIV_SEQ_SIGNED_EN is defined.
// ---------------------------------------------------------------------------
module tb_div_seq;

  localparam int WIDTH = 6;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               acceptEdge;
  } expT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  int  checks     = 0;
  int  errors     = 0;
  int  edgeCount  = 0;
  expT scoreboard[$];

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef DIV_SEQ_SIGNED_EN
    .sgn         (sgn),
`endif
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock; rising edges are counted so latency is measured in edges.
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference results from plain integer arithmetic. SystemVerilog int
  // division truncates toward zero and % takes the dividend sign.
  function automatic expT model(input logic [WIDTH-1:0] ai,
                                input logic [WIDTH-1:0] bi, input logic s);
    expT m;
    int  sa, sbv, qi, ri;
    m.acceptEdge = 0;
    if (bi == 0) begin
      m.q   = '1;
      m.r   = ai;
      m.dbz = 1'b1;
    end else if (!s) begin
      m.q   = ai / bi;
      m.r   = ai % bi;
      m.dbz = 1'b0;
    end else begin
      sa    = int'($signed(ai));
      sbv   = int'($signed(bi));
      qi    = sa / sbv;
      ri    = sa % sbv;
      m.q   = qi[WIDTH-1:0];
      m.r   = ri[WIDTH-1:0];
      m.dbz = 1'b0;
    end
    return m;
  endfunction

  // Called just after a falling edge: presents a start for the next rising
  // edge, records the expectation, then drops start after that edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ai,
                               input logic [WIDTH-1:0] bi, input logic s);
    expT e;
    e            = model(ai, bi, s);
    e.acceptEdge = edgeCount + 1;
    scoreboard.push_back(e);
    start = 1'b1;
    a     = ai;
    b     = bi;
    sgn   = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then compares against the oldest expectation.
  // Returns at the falling edge inside the DONE cycle.
  task automatic waitDone();
    int  guard;
    expT e;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      checkOutput("doneTimeout", 32'd0, 32'd1);
      if (scoreboard.size() > 0) void'(scoreboard.pop_front());
    end else if (scoreboard.size() == 0) begin
      checkOutput("unexpectedDone", 32'd1, 32'd0);
    end else begin
      e = scoreboard.pop_front();
      checkOutput("q", q, e.q);
      checkOutput("r", r, e.r);
      checkOutput("divByZero", div_by_zero, e.dbz);
      checkOutput("latency", edgeCount - e.acceptEdge + 1, e.dbz ? 1 : WIDTH + 1);
      checkOutput("readyInDone", ready, 1);
    end
  endtask

  // Main sequence.
  initial begin
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    checkOutput("rstQ", q, 0);
    checkOutput("rstR", r, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstDbz", div_by_zero, 0);
    checkOutput("rstReady", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Divide by zero, then a normal divide must clear the flag.
    applyStimulus(6'd45, 6'd0, 1'b0);
    waitDone();
    @(negedge clk);
    checkOutput("donePulseDbz", done, 0);
    applyStimulus(6'd45, 6'd9, 1'b0);
    waitDone();
    @(negedge clk);

    // Start pulsed during RUN must be ignored.
    applyStimulus(6'd50, 6'd7, 1'b0);
    checkOutput("busyReady", ready, 0);
    start = 1'b1;
    a     = 6'd1;
    b     = 6'd1;
    @(negedge clk);
    start = 1'b0;
    waitDone();
    @(negedge clk);
    checkOutput("donePulse", done, 0);
    checkOutput("readyIdle", ready, 1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("ignoredStartDone", pulses, 0);

    // Back-to-back: second start issued in the DONE cycle.
    applyStimulus(6'd10, 6'd3, 1'b0);
    waitDone();
    applyStimulus(6'd63, 6'd2, 1'b0);
    waitDone();
    @(negedge clk);

    // Operands wander while the division runs.
    applyStimulus(6'd40, 6'd3, 1'b0);
    repeat (4) begin
      a = 6'($urandom);
      b = 6'($urandom);
      @(negedge clk);
    end
    waitDone();
    @(negedge clk);

    // Reset in the third RUN cycle aborts with no done afterwards.
    applyStimulus(6'd60, 6'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    scoreboard.delete();
    checkOutput("abortQ", q, 0);
    checkOutput("abortR", r, 0);
    checkOutput("abortReady", ready, 1);
    checkOutput("abortDone", done, 0);
    checkOutput("abortDbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abortNoDone", pulses, 0);
    applyStimulus(6'd60, 6'd5, 1'b0);
    waitDone();
    @(negedge clk);

`ifdef DIV_SEQ_SIGNED_EN
    // Signed operands: -20/3, 20/-3, and the -32/-1 wrap.
    applyStimulus(6'd44, 6'd3, 1'b1);
    waitDone();
    applyStimulus(6'd20, 6'd61, 1'b1);
    waitDone();
    applyStimulus(6'd32, 6'd63, 1'b1);
    waitDone();
    applyStimulus(6'd45, 6'd0, 1'b1);
    waitDone();
    @(negedge clk);
`endif

    // Every nonzero-divisor pair; some launched back to back, some after
    // an idle cycle.
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 1; bi < 64; bi++) begin
        if ((ai + bi) % 3 == 0) @(negedge clk);
        applyStimulus(6'(ai), 6'(bi), 1'b0);
        waitDone();
      end
    end
    @(negedge clk);
    checkOutput("scoreboardEmpty", scoreboard.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
